// File: rtl/shot_seq.sv
// shot_seq: shot sequencer that drives per-core resets, repeats shots and inserts settling gaps.
// Optional per-shot watchdog is built when SHOT_SEQ_WATCHDOG_EN is defined.
module shot_seq #(
    parameter int NPROC    = 4,
    parameter int DLYWIDTH = 24,
    parameter int TOWIDTH  = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stb_start,
    input  logic                stb_abort,
    input  logic [31:0]         nshot,
    input  logic [DLYWIDTH-1:0] shotdelay,
    input  logic [TOWIDTH-1:0]  timeout,
    input  logic [NPROC-1:0]    procmask,
    input  logic [NPROC-1:0]    procdone,
    output logic [NPROC-1:0]    procreset,
    output logic                resetacc,
    output logic                busy,
    output logic                lastshotdone,
    output logic [31:0]         shotcnt,
    output logic                timedout,
    output logic [2:0]          state_mon
);
    typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, RUN = 3'd2, GAP = 3'd3, DONE = 3'd4, ABORT = 3'd5} state_t;

    state_t              state_q, state_d;
    logic [31:0]         nshot_q, nshot_d, shotcnt_q, shotcnt_d, nshot_eff;
    logic [DLYWIDTH-1:0] delay_q, delay_d, dly_q, dly_d;
    logic [NPROC-1:0]    mask_q, mask_d, procreset_q;
    logic                resetacc_q, busy_q, lastshotdone_q;
    logic                start_ok, complete, last, wd_fire;

    assign start_ok  = state_q == IDLE && stb_start;
    assign complete  = &(procdone | ~mask_q);
    assign nshot_eff = nshot_q == 32'd0 ? 32'd1 : nshot_q;
    assign last      = shotcnt_q + 32'd1 >= nshot_eff;

`ifdef SHOT_SEQ_WATCHDOG_EN
    logic [TOWIDTH-1:0] timeout_q, timeout_d, wd_q, wd_d;
    logic               timedout_q, timedout_d;

    assign wd_fire    = state_q == RUN && timeout_q != '0 && wd_q == timeout_q - TOWIDTH'(1);
    assign timeout_d  = start_ok ? timeout : timeout_q;
    assign wd_d       = state_q == START ? '0 : state_q == RUN ? wd_q + TOWIDTH'(1) : wd_q;
    // An abort on the same cycle outranks the watchdog, so the flag is not set then.
    assign timedout_d = start_ok ? 1'b0 : (wd_fire && !stb_abort) ? 1'b1 : timedout_q;
    assign timedout   = timedout_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_q  <= '0;
            wd_q       <= '0;
            timedout_q <= 1'b0;
        end else begin
            timeout_q  <= timeout_d;
            wd_q       <= wd_d;
            timedout_q <= timedout_d;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^timeout;
    assign wd_fire        = 1'b0;
    assign timedout       = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        if (state_q != IDLE && stb_abort)
            state_d = ABORT;
        else
            case (state_q)
                IDLE:    state_d = stb_start ? START : IDLE;
                START:   state_d = RUN;
                RUN:     state_d = wd_fire ? ABORT : complete ? (last ? DONE : GAP) : RUN;
                GAP:     state_d = dly_q == '0 ? START : GAP;
                default: state_d = IDLE;
            endcase
    end

    assign nshot_d   = start_ok ? nshot : nshot_q;
    assign delay_d   = start_ok ? shotdelay : delay_q;
    assign mask_d    = start_ok ? procmask : mask_q;
    assign dly_d     = (state_d == GAP && state_q != GAP) ? delay_q :
                       (state_q == GAP && dly_q != '0) ? dly_q - DLYWIDTH'(1) : dly_q;
    assign shotcnt_d = start_ok ? 32'd0 :
                       (state_q == RUN && (state_d == GAP || state_d == DONE)) ? shotcnt_q + 32'd1 : shotcnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            nshot_q        <= '0;
            delay_q        <= '0;
            mask_q         <= '0;
            dly_q          <= '0;
            shotcnt_q      <= '0;
            procreset_q    <= '1;
            resetacc_q     <= 1'b0;
            busy_q         <= 1'b0;
            lastshotdone_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            nshot_q        <= nshot_d;
            delay_q        <= delay_d;
            mask_q         <= mask_d;
            dly_q          <= dly_d;
            shotcnt_q      <= shotcnt_d;
            procreset_q    <= (state_d == START || state_d == RUN) ? ~mask_d : '1;
            resetacc_q     <= start_ok;
            busy_q         <= state_d != IDLE;
            lastshotdone_q <= state_d == DONE;
        end
    end

    assign procreset    = procreset_q;
    assign resetacc     = resetacc_q;
    assign busy         = busy_q;
    assign lastshotdone = lastshotdone_q;
    assign shotcnt      = shotcnt_q;
    assign state_mon    = state_q;
endmodule

// File: tb/tb_shot_seq.sv
// tb_shot_seq: vector table for a short run plus directed multi-shot, mask, watchdog, abort and reset sequences.
module tb_shot_seq;
    logic        clk = 1'b0, reset = 1'b0, stb_start = 1'b0, stb_abort = 1'b0;
    logic [31:0] nshot = 32'd0, timeout = 32'd0;
    logic [23:0] shotdelay = 24'd0;
    logic [3:0]  procmask = 4'h0, procdone = 4'h0;
    logic [3:0]  procreset;
    logic        resetacc, busy, lastshotdone, timedout;
    logic [31:0] shotcnt;
    logic [2:0]  state_mon;

    int tests = 0, fails = 0;
    int windows, lsd_cnt, gaps_bad, mask_bad;

    typedef struct {
        logic        start, abort;
        logic [3:0]  done;
        logic [2:0]  st;
        logic [3:0]  pr;
        logic        busy;
        logic [31:0] cnt;
        logic        racc, lsd;
    } vec_t;
    vec_t vecs[14];

    shot_seq dut (
        .clk(clk), .reset(reset), .stb_start(stb_start), .stb_abort(stb_abort),
        .nshot(nshot), .shotdelay(shotdelay), .timeout(timeout), .procmask(procmask),
        .procdone(procdone), .procreset(procreset), .resetacc(resetacc), .busy(busy),
        .lastshotdone(lastshotdone), .shotcnt(shotcnt), .timedout(timedout), .state_mon(state_mon)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Starts a run and models the cores: done rises lat cycles after procreset falls.
    task automatic run_shots(input int lat, input int abort_shot);
        int   low_cnt = 1, high_run = 0;
        logic was_low = 1'b1, was_gap = 1'b0;
        windows = 1; lsd_cnt = 0; gaps_bad = 0; mask_bad = 0;
        stb_start = 1'b1;
        tick;
        stb_start = 1'b0;
        for (int c = 0; c < 600 && busy; c++) begin
            if (abort_shot > 0 && state_mon == 3'd3 && shotcnt == 32'(abort_shot)) begin
                stb_abort = 1'b1;
                tick;
                stb_abort = 1'b0;
                chk("abort_state", 32'(state_mon), 32'd5);
                tick;
                chk("abort_idle", 32'(state_mon), 32'd0);
                chk("abort_cnt", shotcnt, 32'(abort_shot));
                chk("abort_preset", 32'(procreset), 32'hF);
                chk("abort_busy", 32'(busy), 32'd0);
                procdone = 4'h0;
                return;
            end
            procdone = low_cnt >= lat ? procmask : 4'h0;
            tick;
            if (procreset != 4'hF) begin
                if (!was_low) begin
                    windows++;
                    if (high_run != int'(shotdelay) + 1) gaps_bad++;
                end
                low_cnt++; high_run = 0; was_low = 1'b1;
            end else begin
                low_cnt = 0; high_run++; was_low = 1'b0;
            end
            if ((procreset | procmask) != 4'hF) mask_bad++;
            lsd_cnt += int'(lastshotdone);
            if (state_mon == 3'd3 && !was_gap) chk("gap_shotcnt", shotcnt, 32'(windows));
            was_gap = state_mon == 3'd3;
        end
        procdone = 4'h0;
        if (busy) chk("run_bound", 32'(busy), 32'd0);
    endtask

    initial begin
        //            start abort done  st    pr    busy cnt  racc lsd
        vecs[0]  = '{1'b1, 1'b0, 4'h0, 3'd1, 4'hA, 1'b1, 32'd0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 4'h0, 3'd2, 4'hA, 1'b1, 32'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 4'h1, 3'd2, 4'hA, 1'b1, 32'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 4'h5, 3'd3, 4'hF, 1'b1, 32'd1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 4'h0, 3'd3, 4'hF, 1'b1, 32'd1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 4'h0, 3'd1, 4'hA, 1'b1, 32'd1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 4'h0, 3'd2, 4'hA, 1'b1, 32'd1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 4'hF, 3'd4, 4'hF, 1'b1, 32'd2, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 4'h0, 3'd0, 4'hF, 1'b0, 32'd2, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 4'h0, 3'd0, 4'hF, 1'b0, 32'd2, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 4'h0, 3'd1, 4'hA, 1'b1, 32'd0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 4'h0, 3'd2, 4'hA, 1'b1, 32'd0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 4'h5, 3'd5, 4'hF, 1'b1, 32'd0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 4'h0, 3'd0, 4'hF, 1'b0, 32'd0, 1'b0, 1'b0};

        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(state_mon), 32'd0);
        chk("rst_preset", 32'(procreset), 32'hF);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", shotcnt, 32'd0);
        chk("rst_racc", 32'(resetacc), 32'd0);
        chk("rst_lsd", 32'(lastshotdone), 32'd0);
        chk("rst_to", 32'(timedout), 32'd0);
        reset = 1'b0;
        tick;

        nshot = 32'd2; shotdelay = 24'd1; timeout = 32'd0; procmask = 4'h5;
        for (int i = 0; i < 14; i++) begin
            stb_start = vecs[i].start; stb_abort = vecs[i].abort; procdone = vecs[i].done;
            tick;
            chk($sformatf("v%0d_state", i), 32'(state_mon), 32'(vecs[i].st));
            chk($sformatf("v%0d_preset", i), 32'(procreset), 32'(vecs[i].pr));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
            chk($sformatf("v%0d_cnt", i), shotcnt, vecs[i].cnt);
            chk($sformatf("v%0d_racc", i), 32'(resetacc), 32'(vecs[i].racc));
            chk($sformatf("v%0d_lsd", i), 32'(lastshotdone), 32'(vecs[i].lsd));
            chk($sformatf("v%0d_to", i), 32'(timedout), 32'd0);
        end
        stb_start = 1'b0; stb_abort = 1'b0; procdone = 4'h0;
        tick;

        nshot = 32'd3; shotdelay = 24'd4; procmask = 4'hF;
        run_shots(10, 0);
        chk("basic_windows", 32'(windows), 32'd3);
        chk("basic_gaps_bad", 32'(gaps_bad), 32'd0);
        chk("basic_lsd", 32'(lsd_cnt), 32'd1);
        chk("basic_cnt", shotcnt, 32'd3);
        chk("basic_busy", 32'(busy), 32'd0);

        nshot = 32'd0; shotdelay = 24'd2;
        run_shots(1, 0);
        chk("n0_windows", 32'(windows), 32'd1);
        chk("n0_lsd", 32'(lsd_cnt), 32'd1);
        chk("n0_cnt", shotcnt, 32'd1);

        nshot = 32'd2; shotdelay = 24'd3; procmask = 4'h5;
        run_shots(4, 0);
        chk("mask_hold", 32'(mask_bad), 32'd0);
        chk("mask_windows", 32'(windows), 32'd2);
        chk("mask_lsd", 32'(lsd_cnt), 32'd1);
        chk("mask_cnt", shotcnt, 32'd2);

        nshot = 32'd5; shotdelay = 24'd10; procmask = 4'hF;
        run_shots(3, 2);
        chk("abort_lsd", 32'(lsd_cnt), 32'd0);

        nshot = 32'd1; timeout = 32'd20; procdone = 4'h0;
        stb_start = 1'b1;
        tick;
        stb_start = 1'b0;
        chk("wd_start", 32'(state_mon), 32'd1);
        tick;
        chk("wd_run", 32'(state_mon), 32'd2);
`ifdef SHOT_SEQ_WATCHDOG_EN
        repeat (19) tick;
        chk("wd_still_run", 32'(state_mon), 32'd2);
        tick;
        chk("wd_abort", 32'(state_mon), 32'd5);
        chk("wd_flag", 32'(timedout), 32'd1);
        chk("wd_lsd", 32'(lastshotdone), 32'd0);
        tick;
        chk("wd_idle", 32'(state_mon), 32'd0);
        chk("wd_sticky", 32'(timedout), 32'd1);
        stb_start = 1'b1;
        tick;
        stb_start = 1'b0;
        chk("wd_clear", 32'(timedout), 32'd0);
`else
        repeat (30) tick;
        chk("nowd_run", 32'(state_mon), 32'd2);
        chk("nowd_flag", 32'(timedout), 32'd0);
`endif
        stb_abort = 1'b1;
        tick;
        stb_abort = 1'b0;
        tick;
        chk("wd_end_idle", 32'(state_mon), 32'd0);
        timeout = 32'd0;

        nshot = 32'd3; shotdelay = 24'd2; procmask = 4'hF;
        stb_start = 1'b1;
        tick;
        stb_start = 1'b0;
        tick;
        procdone = 4'hF;
        tick;
        procdone = 4'h0;
        chk("ar_gap", 32'(state_mon), 32'd3);
        repeat (4) tick;
        chk("ar_run", 32'(state_mon), 32'd2);
        chk("ar_cnt1", shotcnt, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("ar_state", 32'(state_mon), 32'd0);
        chk("ar_preset", 32'(procreset), 32'hF);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_cnt", shotcnt, 32'd0);
        chk("ar_racc", 32'(resetacc), 32'd0);
        chk("ar_lsd", 32'(lastshotdone), 32'd0);
        chk("ar_to", 32'(timedout), 32'd0);
        reset = 1'b0;
        tick;
        chk("ar_after", 32'(state_mon), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
